// File: rtl/cmp_seq_if.sv
`default_nettype none
// ============================================================================
// cmp_seq_if : start/flush/operand request and ready/done/result response
// Revision   : 1.0
// ============================================================================
interface cmp_seq_if #(
  parameter int WIDTH = 32
);
  logic             i_Start;
  logic             i_Flush;
  logic [WIDTH-1:0] i_RsIn;
  logic [WIDTH-1:0] i_RtIn;
  logic [3:0]       i_Mode;
  logic             o_Ready;
  logic             o_Done;
  logic             o_Result;

  modport master (
    output i_Start, i_Flush, i_RsIn, i_RtIn, i_Mode,
    input  o_Ready, o_Done, o_Result
  );

  modport slave (
    input  i_Start, i_Flush, i_RsIn, i_RtIn, i_Mode,
    output o_Ready, o_Done, o_Result
  );
endinterface
`default_nettype wire

// File: rtl/cmp_seq.sv
`default_nettype none
// ============================================================================
// cmp_seq : multi-cycle MSB-first chunked branch condition comparator
// Revision: 1.0
// ============================================================================
module cmp_seq #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  cmp_seq_if.slave   bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] M_EQ  = 4'd0;
  localparam logic [3:0] M_NEQ = 4'd1;
  localparam logic [3:0] M_LEZ = 4'd2;
  localparam logic [3:0] M_GEZ = 4'd3;
  localparam logic [3:0] M_LZ  = 4'd4;
  localparam logic [3:0] M_GZ  = 4'd5;
  localparam logic [3:0] M_LT  = 4'd6;
  localparam logic [3:0] M_GE  = 4'd7;
  localparam logic [3:0] M_LTU = 4'd8;
  localparam logic [3:0] M_GEU = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [3:0]         mode_q;
  logic [IDX_W-1:0]   idx;
  logic               eq;
  logic               lt;
  logic               done_q;
  logic               result_q;

  logic [CHUNK-1:0]   a_chunks [N];
  logic [CHUNK-1:0]   b_chunks [N];
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic               new_diff;
  logic               eq_nxt;
  logic               lt_nxt;
  logic               finish;
  logic               res_nxt;
  logic               zero_mode;
  logic               signed_mode;
  logic [WIDTH-1:0]   a_lat;
  logic [WIDTH-1:0]   b_lat;

  generate
    for (genvar g = 0; g < N; g++) begin : g_chunk
      assign a_chunks[g] = a_q[g*CHUNK +: CHUNK];
      assign b_chunks[g] = b_q[g*CHUNK +: CHUNK];
    end
  endgenerate

  // Signed orderings become unsigned by flipping both sign bits at accept.
  always_comb begin
    zero_mode   = (bus.i_Mode >= M_LEZ) && (bus.i_Mode <= M_GZ);
    signed_mode = (bus.i_Mode >= M_LEZ) && (bus.i_Mode <= M_GE);
    a_lat       = bus.i_RsIn;
    b_lat       = zero_mode ? '0 : bus.i_RtIn;
    if (signed_mode) begin
      a_lat[WIDTH-1] = ~a_lat[WIDTH-1];
      b_lat[WIDTH-1] = ~b_lat[WIDTH-1];
    end
  end

  always_comb begin
    a_chunk  = a_chunks[idx];
    b_chunk  = b_chunks[idx];
    new_diff = eq && (a_chunk != b_chunk);
    eq_nxt   = eq && !new_diff;
    lt_nxt   = new_diff ? (a_chunk < b_chunk) : lt;
    finish   = (idx == '0) || ((EARLY_EXIT != 0) && new_diff);
    case (mode_q)
      M_EQ:         res_nxt = eq_nxt;
      M_NEQ:        res_nxt = !eq_nxt;
      M_LEZ:        res_nxt = lt_nxt || eq_nxt;
      M_GEZ:        res_nxt = !lt_nxt;
      M_LZ:         res_nxt = lt_nxt;
      M_GZ:         res_nxt = !lt_nxt && !eq_nxt;
      M_LT, M_LTU:  res_nxt = lt_nxt;
      M_GE, M_GEU:  res_nxt = !lt_nxt;
      default:      res_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= '0;
      idx      <= '0;
      eq       <= 1'b0;
      lt       <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.i_Start) begin
            a_q    <= a_lat;
            b_q    <= b_lat;
            mode_q <= bus.i_Mode;
            idx    <= IDX_W'(N - 1);
            eq     <= 1'b1;
            lt     <= 1'b0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (bus.i_Flush) begin
            state <= IDLE;
          end else begin
            eq <= eq_nxt;
            lt <= lt_nxt;
            if (finish) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= res_nxt;
            end else begin
              idx <= idx - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Ready  = (state != RUN);
  assign bus.o_Done   = done_q;
  assign bus.o_Result = result_q;
endmodule
`default_nettype wire

// File: tb/tb_cmp_seq.sv
`default_nettype none
// ============================================================================
// tb_cmp_seq : directed checks of cmp_seq (WIDTH=32, CHUNK=8, EARLY_EXIT=1)
// Revision   : 1.0
// ============================================================================
module tb_cmp_seq;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  cmp_seq_if #(.WIDTH(32)) bus ();

  cmp_seq #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the request during cycle 0; returns positioned in cycle 1.
  task automatic start_cmp(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    bus.i_Start = 1'b1;
    bus.i_Mode  = m;
    bus.i_RsIn  = a;
    bus.i_RtIn  = b;
    step();
    bus.i_Start = 1'b0;
    bus.i_RsIn  = 32'hDEAD_BEEF;
    bus.i_RtIn  = 32'h0BAD_F00D;
  endtask

  // Returns the cycle index at which o_Done is first seen, or -1 on timeout.
  task automatic wait_done(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = -1;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (bus.o_Done === 1'b1) begin
        seen = 1'b1;
        cyc  = c;
      end else begin
        step();
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total++; if (bus.o_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.o_Ready); end
    total++; if (bus.o_Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.o_Done); end
    total++; if (bus.o_Result !== 1'b0) begin bad++; $display("FAIL reset_result got=%b exp=0", bus.o_Result); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_equal();
    int cyc;
    start_cmp(4'd0, 32'h1234_5678, 32'h1234_5678);
    total++; if (bus.o_Ready !== 1'b0) begin bad++; $display("FAIL eq_busy got=%b exp=0", bus.o_Ready); end
    wait_done(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL eq_latency got=%0d exp=5", cyc); end
    total++; if (bus.o_Result !== 1'b1) begin bad++; $display("FAIL eq_result got=%b exp=1", bus.o_Result); end
    total++; if (bus.o_Ready !== 1'b1) begin bad++; $display("FAIL eq_done_ready got=%b exp=1", bus.o_Ready); end
    step();
    total++; if (bus.o_Done !== 1'b0) begin bad++; $display("FAIL eq_done_pulse got=%b exp=0", bus.o_Done); end
    start_cmp(4'd1, 32'h1234_5678, 32'h1234_5678);
    wait_done(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL neq_latency got=%0d exp=5", cyc); end
    total++; if (bus.o_Result !== 1'b0) begin bad++; $display("FAIL neq_result got=%b exp=0", bus.o_Result); end
    step();
  endtask

  task automatic test_signed();
    int cyc;
    start_cmp(4'd6, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done(cyc);
    total++; if (cyc !== 2) begin bad++; $display("FAIL lt_latency got=%0d exp=2", cyc); end
    total++; if (bus.o_Result !== 1'b1) begin bad++; $display("FAIL lt_result got=%b exp=1", bus.o_Result); end
    step();
    start_cmp(4'd8, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done(cyc);
    total++; if (cyc !== 2) begin bad++; $display("FAIL ltu_latency got=%0d exp=2", cyc); end
    total++; if (bus.o_Result !== 1'b0) begin bad++; $display("FAIL ltu_result got=%b exp=0", bus.o_Result); end
    step();
    start_cmp(4'd9, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done(cyc);
    total++; if (bus.o_Result !== 1'b1) begin bad++; $display("FAIL geu_result got=%b exp=1", bus.o_Result); end
    step();
  endtask

  task automatic test_zero();
    int cyc;
    // B is driven with non-zero junk; zero modes must ignore it.
    start_cmp(4'd5, 32'h0000_0100, 32'hFFFF_FFFF);
    wait_done(cyc);
    total++; if (cyc !== 4) begin bad++; $display("FAIL gz_latency got=%0d exp=4", cyc); end
    total++; if (bus.o_Result !== 1'b1) begin bad++; $display("FAIL gz_result got=%b exp=1", bus.o_Result); end
    step();
    start_cmp(4'd5, 32'h0000_0000, 32'h0000_0007);
    wait_done(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL gz0_latency got=%0d exp=5", cyc); end
    total++; if (bus.o_Result !== 1'b0) begin bad++; $display("FAIL gz0_result got=%b exp=0", bus.o_Result); end
    step();
    start_cmp(4'd2, 32'h0000_0000, 32'h8000_0000);
    wait_done(cyc);
    total++; if (bus.o_Result !== 1'b1) begin bad++; $display("FAIL lez0_result got=%b exp=1", bus.o_Result); end
    step();
    start_cmp(4'd4, 32'h8000_0000, 32'h0000_0000);
    wait_done(cyc);
    total++; if (cyc !== 2) begin bad++; $display("FAIL lz_latency got=%0d exp=2", cyc); end
    total++; if (bus.o_Result !== 1'b1) begin bad++; $display("FAIL lz_result got=%b exp=1", bus.o_Result); end
    step();
  endtask

  task automatic test_flush();
    int cyc;
    int pulses;
    // o_Result is 1 from the preceding LZ compare.
    start_cmp(4'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    total++; if (bus.o_Ready !== 1'b0) begin bad++; $display("FAIL flush_busy1 got=%b exp=0", bus.o_Ready); end
    bus.i_Start = 1'b1;
    bus.i_Mode  = 4'd1;
    step();
    bus.i_Start = 1'b0;
    bus.i_Flush = 1'b1;
    total++; if (bus.o_Ready !== 1'b0) begin bad++; $display("FAIL flush_busy2 got=%b exp=0", bus.o_Ready); end
    step();
    bus.i_Flush = 1'b0;
    total++; if (bus.o_Ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", bus.o_Ready); end
    total++; if (bus.o_Result !== 1'b1) begin bad++; $display("FAIL flush_result_hold got=%b exp=1", bus.o_Result); end
    pulses = (bus.o_Done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.o_Done === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", pulses); end
    // Flush while idle must not block a simultaneous start.
    bus.i_Flush = 1'b1;
    start_cmp(4'd1, 32'h0000_0042, 32'h0000_0042);
    bus.i_Flush = 1'b0;
    wait_done(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL idle_flush_latency got=%0d exp=5", cyc); end
    total++; if (bus.o_Result !== 1'b0) begin bad++; $display("FAIL idle_flush_result got=%b exp=0", bus.o_Result); end
    step();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int pulses;
    start_cmp(4'd0, 32'h0000_0001, 32'h0000_0001);
    wait_done(cyc);
    total++; if (bus.o_Result !== 1'b1) begin bad++; $display("FAIL prerst_result got=%b exp=1", bus.o_Result); end
    step();
    start_cmp(4'd0, 32'h0000_0001, 32'h0000_0001);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    total++; if (bus.o_Result !== 1'b0) begin bad++; $display("FAIL rst_run_result got=%b exp=0", bus.o_Result); end
    total++; if (bus.o_Ready !== 1'b1) begin bad++; $display("FAIL rst_run_ready got=%b exp=1", bus.o_Ready); end
    pulses = (bus.o_Done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.o_Done === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_run_no_done got=%0d exp=0", pulses); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_cmp(4'd3, 32'h7FFF_FFFF, 32'h0000_0000);
    wait_done(cyc);
    total++; if (bus.o_Result !== 1'b1) begin bad++; $display("FAIL b2b_first_result got=%b exp=1", bus.o_Result); end
    start_cmp(4'hF, 32'h0000_0000, 32'h0000_0000);
    total++; if (bus.o_Done !== 1'b0) begin bad++; $display("FAIL b2b_no_double got=%b exp=0", bus.o_Done); end
    total++; if (bus.o_Ready !== 1'b0) begin bad++; $display("FAIL b2b_accepted got=%b exp=0", bus.o_Ready); end
    wait_done(cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL b2b_latency got=%0d exp=5", cyc); end
    total++; if (bus.o_Result !== 1'b0) begin bad++; $display("FAIL b2b_invalid_result got=%b exp=0", bus.o_Result); end
    step();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    bus.i_Start = 1'b0;
    bus.i_Flush = 1'b0;
    bus.i_RsIn  = '0;
    bus.i_RtIn  = '0;
    bus.i_Mode  = '0;
    test_reset();
    test_equal();
    test_signed();
    test_zero();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
